mp64_mbox_initiator: RTL and testbench

//  Per-core command engine and bus initiator for the mailbox/spinlock MMIO block.
//  - Turns one command into the MMIO byte sequence that the mailbox/spinlock block

---
 rtl/mp64_mbox_initiator_if.sv | 30 +++
 rtl/mp64_mbox_initiator.sv | 155 +++++++++++++++
 tb/tb_mp64_mbox_initiator.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mp64_mbox_initiator_if.sv
// Command port and MMIO bus of the mailbox/spinlock initiator.
// master = the engine side, slave = core plus arbiter side.
interface mp64_mbox_initiator_if #(
  parameter int ID_BITS = 2
);
  logic               cmd_valid;
  logic               cmd_ready;
  logic [1:0]         cmd_op;
  logic [ID_BITS-1:0] cmd_core;
  logic [2:0]         cmd_lock;
  logic [63:0]        cmd_data;
  logic               done;
  logic               done_err;
  logic               bus_req;
  logic [11:0]        bus_addr;
  logic [7:0]         bus_wdata;
  logic               bus_wen;
  logic [7:0]         bus_rdata;
  logic               bus_ack;

  modport master (
    input  cmd_valid, cmd_op, cmd_core, cmd_lock, cmd_data, bus_rdata, bus_ack,
    output cmd_ready, done, done_err, bus_req, bus_addr, bus_wdata, bus_wen
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_core, cmd_lock, cmd_data, bus_rdata, bus_ack,
    input  cmd_ready, done, done_err, bus_req, bus_addr, bus_wdata, bus_wen
  );
endinterface

// File: rtl/mp64_mbox_initiator.sv
// Per-core engine: one command in, MMIO byte sequence out (send, ack, lock w/ retry, unlock).
// Bus outputs decode from held state so they stay stable until bus_ack; cmd_ready only in IDLE.
module mp64_mbox_initiator #(
  parameter int          N_CORES       = 4,
  parameter int          ID_BITS       = 2,
  parameter int          SPIN_MAX      = 255,
  parameter int          BACKOFF       = 4,
  parameter logic [11:0] MBOX_SEND     = 12'h008,
  parameter logic [11:0] MBOX_ACK      = 12'h00C,
  parameter logic [11:0] SLOCK_ACQUIRE = 12'h000,
  parameter logic [11:0] SLOCK_RELEASE = 12'h001
) (
  input  logic clk,
  input  logic rst_n,
  mp64_mbox_initiator_if.master mb
);

  localparam logic [1:0] OP_SEND   = 2'd0;
  localparam logic [1:0] OP_LOCK   = 2'd1;
  localparam logic [1:0] OP_UNLOCK = 2'd2;
  localparam logic [1:0] OP_ACK    = 2'd3;

  localparam int AW = (SPIN_MAX > 1) ? $clog2(SPIN_MAX + 1) : 1;
  localparam int BW = (BACKOFF > 1) ? $clog2(BACKOFF) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_WRDATA, S_SEND, S_ACKW, S_UNLOCK, S_LOCK_RD, S_BACKOFF, S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [ID_BITS-1:0] core_q;
  logic [2:0]         lock_q;
  logic [63:0]        data_q;
  logic [2:0]         idx_q;
  logic [AW-1:0]      att_q, att_nxt;
  logic [BW-1:0]      bo_q;
  logic               err_q;
  logic               core_bad, lock_timeout;
  logic [11:0]        lock_base;
  logic               unused_rdata;

  assign unused_rdata = ^mb.bus_rdata[7:1];
  assign lock_base    = 12'h600 + {7'd0, lock_q, 2'b00};

  // Only SEND and ACK carry a core index that must name a real core.
  assign core_bad = ((mb.cmd_op == OP_SEND) || (mb.cmd_op == OP_ACK)) &&
                    (32'(mb.cmd_core) >= 32'(N_CORES));

  // Saturates so SPIN_MAX=0 (retry forever) can never wrap into a false timeout.
  assign att_nxt      = (&att_q) ? att_q : att_q + 1'b1;
  assign lock_timeout = mb.bus_rdata[0] && (SPIN_MAX != 0) && (att_nxt == AW'(SPIN_MAX));

  always_comb begin
    state_d      = state_q;
    mb.cmd_ready = 1'b0;
    mb.done      = 1'b0;
    mb.done_err  = 1'b0;
    mb.bus_req   = 1'b0;
    mb.bus_addr  = 12'h000;
    mb.bus_wdata = 8'h00;
    mb.bus_wen   = 1'b0;
    case (state_q)
      S_IDLE: begin
        mb.cmd_ready = 1'b1;
        if (mb.cmd_valid) begin
          if (core_bad) state_d = S_DONE;
          else begin
            case (mb.cmd_op)
              OP_SEND:   state_d = S_WRDATA;
              OP_LOCK:   state_d = S_LOCK_RD;
              OP_UNLOCK: state_d = S_UNLOCK;
              default:   state_d = S_ACKW;
            endcase
          end
        end
      end
      S_WRDATA: begin
        mb.bus_req   = 1'b1;
        mb.bus_wen   = 1'b1;
        mb.bus_addr  = 12'h500 + {9'd0, idx_q};
        mb.bus_wdata = data_q[{idx_q, 3'b000} +: 8];
        if (mb.bus_ack && (idx_q == 3'd7)) state_d = S_SEND;
      end
      S_SEND: begin
        mb.bus_req   = 1'b1;
        mb.bus_wen   = 1'b1;
        mb.bus_addr  = 12'h500 | MBOX_SEND;
        mb.bus_wdata = 8'(core_q);
        if (mb.bus_ack) state_d = S_DONE;
      end
      S_ACKW: begin
        mb.bus_req   = 1'b1;
        mb.bus_wen   = 1'b1;
        mb.bus_addr  = 12'h500 | MBOX_ACK;
        mb.bus_wdata = 8'(core_q);
        if (mb.bus_ack) state_d = S_DONE;
      end
      S_UNLOCK: begin
        mb.bus_req  = 1'b1;
        mb.bus_wen  = 1'b1;
        mb.bus_addr = lock_base + SLOCK_RELEASE;
        if (mb.bus_ack) state_d = S_DONE;
      end
      S_LOCK_RD: begin
        mb.bus_req  = 1'b1;
        mb.bus_addr = lock_base + SLOCK_ACQUIRE;
        if (mb.bus_ack) begin
          if (!mb.bus_rdata[0] || lock_timeout) state_d = S_DONE;
          else                                  state_d = S_BACKOFF;
        end
      end
      S_BACKOFF: begin
        if (bo_q == BW'(BACKOFF - 1)) state_d = S_LOCK_RD;
      end
      S_DONE: begin
        mb.done     = 1'b1;
        mb.done_err = err_q;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      core_q  <= '0;
      lock_q  <= '0;
      data_q  <= '0;
      idx_q   <= '0;
      att_q   <= '0;
      bo_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && mb.cmd_valid) begin
        core_q <= mb.cmd_core;
        lock_q <= mb.cmd_lock;
        data_q <= mb.cmd_data;
        idx_q  <= '0;
        att_q  <= '0;
        bo_q   <= '0;
        err_q  <= core_bad;
      end
      if (state_q == S_WRDATA && mb.bus_ack) idx_q <= idx_q + 1'b1;
      if (state_q == S_LOCK_RD && mb.bus_ack) begin
        att_q <= att_nxt;
        bo_q  <= '0;
        err_q <= lock_timeout;
      end
      if (state_q == S_BACKOFF) bo_q <= bo_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_mp64_mbox_initiator.sv
// Directed bench for mp64_mbox_initiator: vector table plus stall and mid-command reset sequences.
module tb_mp64_mbox_initiator;

  localparam int BACKOFF = 4;
  localparam logic [1:0] OP_SEND = 2'd0, OP_LOCK = 2'd1, OP_UNLOCK = 2'd2, OP_ACK = 2'd3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mp64_mbox_initiator_if #(.ID_BITS(3)) bif ();

  mp64_mbox_initiator #(
    .N_CORES(4), .ID_BITS(3), .SPIN_MAX(3), .BACKOFF(BACKOFF),
    .MBOX_SEND(12'h008), .MBOX_ACK(12'h00C),
    .SLOCK_ACQUIRE(12'h000), .SLOCK_RELEASE(12'h001)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .mb(bif)
  );

  typedef struct {
    logic [1:0]  op;
    logic [2:0]  core;
    logic [2:0]  lock;
    logic [63:0] data;
    int          busy;
    logic        exp_err;
    int          exp_ntx;
    int          exp_lat;
    logic [11:0] exp_addr;
    logic [7:0]  exp_wdata;
    logic        exp_wen;
  } vec_t;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Bus responder / monitor state
  int          tx_n = 0;
  logic [11:0] tx_addr [64];
  logic [7:0]  tx_wdata[64];
  logic        tx_wen  [64];
  int          tx_cyc  [64];
  int          busy_left = 0;
  int          stall_idx = -1;
  int          stall_cnt = 0;
  int          stall_len = 0;
  int          done_cnt = 0;
  int          done_cyc = 0;
  logic        done_err_seen = 1'b0;
  int          cap_cyc = 0;
  int          lat = 0;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Acks on the falling edge so the DUT sees ack in the same cycle as req.
  initial begin
    logic        pend;
    logic [11:0] p_addr;
    logic [7:0]  p_wdata;
    logic        p_wen;
    pend = 1'b0; p_addr = '0; p_wdata = '0; p_wen = 1'b0;
    bif.bus_ack = 1'b0;
    bif.bus_rdata = 8'h00;
    forever begin
      @(negedge clk);
      if (bif.done) begin
        done_cnt++;
        done_cyc = cyc;
        done_err_seen = bif.done_err;
      end
      if (bif.bus_req) begin
        if (pend) begin
          chk("stall_addr_stable", 64'(bif.bus_addr), 64'(p_addr));
          chk("stall_wdata_stable", 64'(bif.bus_wdata), 64'(p_wdata));
          chk("stall_wen_stable", 64'(bif.bus_wen), 64'(p_wen));
        end
        if (tx_n == stall_idx && stall_cnt < stall_len) begin
          stall_cnt++;
          bif.bus_ack = 1'b0;
          bif.bus_rdata = 8'h00;
          pend = 1'b1;
          p_addr = bif.bus_addr; p_wdata = bif.bus_wdata; p_wen = bif.bus_wen;
        end else begin
          pend = 1'b0;
          bif.bus_ack = 1'b1;
          if (!bif.bus_wen && busy_left > 0) begin
            bif.bus_rdata = 8'h01;
            busy_left--;
          end else begin
            bif.bus_rdata = bif.bus_wen ? 8'h00 : 8'hFE;
          end
          if (tx_n < 64) begin
            tx_addr[tx_n] = bif.bus_addr;
            tx_wdata[tx_n] = bif.bus_wdata;
            tx_wen[tx_n] = bif.bus_wen;
            tx_cyc[tx_n] = cyc;
          end
          tx_n++;
        end
      end else begin
        // Idle acks must be ignored by the engine.
        pend = 1'b0;
        bif.bus_ack = 1'b1;
        bif.bus_rdata = 8'hFF;
      end
    end
  end

  task automatic run_cmd(input vec_t v, input string tag);
    int  d0;
    bit  got;
    @(negedge clk);
    chk({tag, "_ready_before"}, 64'(bif.cmd_ready), 64'd1);
    tx_n = 0;
    busy_left = v.busy;
    stall_cnt = 0;
    bif.cmd_op = v.op;
    bif.cmd_core = v.core;
    bif.cmd_lock = v.lock;
    bif.cmd_data = v.data;
    bif.cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    bif.cmd_valid = 1'b0;
    cap_cyc = cyc;
    d0 = done_cnt;
    got = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(posedge clk);
      if (done_cnt != d0) begin
        got = 1'b1;
        break;
      end
    end
    chk({tag, "_done_seen"}, 64'(got), 64'd1);
    lat = done_cyc - cap_cyc;
    @(negedge clk);
    chk({tag, "_done_one_cycle"}, 64'(bif.done), 64'd0);
    chk({tag, "_ready_after"}, 64'(bif.cmd_ready), 64'd1);
    chk({tag, "_done_count"}, 64'(done_cnt - d0), 64'd1);
  endtask

  task automatic check_vec(input vec_t v, input string tag);
    chk({tag, "_err"}, 64'(done_err_seen), 64'(v.exp_err));
    chk({tag, "_latency"}, 64'(lat), 64'(v.exp_lat));
    chk({tag, "_ntx"}, 64'(tx_n), 64'(v.exp_ntx));
    if (v.exp_ntx > 0 && tx_n > 0 && tx_n <= 64) begin
      chk({tag, "_last_addr"}, 64'(tx_addr[tx_n-1]), 64'(v.exp_addr));
      chk({tag, "_last_wen"}, 64'(tx_wen[tx_n-1]), 64'(v.exp_wen));
      if (v.exp_wen) chk({tag, "_last_wdata"}, 64'(tx_wdata[tx_n-1]), 64'(v.exp_wdata));
    end
    if (v.op == OP_SEND && v.exp_ntx == 9 && tx_n >= 8 && tx_n <= 64) begin
      for (int i = 0; i < 8; i++) begin
        chk($sformatf("%s_byte%0d_addr", tag, i), 64'(tx_addr[i]), 64'(12'h500 + i));
        chk($sformatf("%s_byte%0d_wdata", tag, i), 64'(tx_wdata[i]), 64'(v.data[8*i +: 8]));
      end
    end
    if (v.op == OP_LOCK && tx_n <= 64) begin
      for (int i = 1; i < tx_n; i++) begin
        chk($sformatf("%s_retry%0d_gap", tag, i), 64'(tx_cyc[i] - tx_cyc[i-1]), 64'(BACKOFF + 1));
        chk($sformatf("%s_retry%0d_addr", tag, i), 64'(tx_addr[i]), 64'(v.exp_addr));
      end
    end
  endtask

  initial begin
    vec_t v;
    bit   hit;
    bit   send_seen;
    int   d0;
    bif.cmd_valid = 1'b0;
    bif.cmd_op = 2'd0;
    bif.cmd_core = 3'd0;
    bif.cmd_lock = 3'd0;
    bif.cmd_data = 64'd0;

    //         op         core  lock  data                    busy err ntx lat addr     wdata  wen
    vecs[0] = '{OP_SEND,   3'd2, 3'd0, 64'h1122334455667788, 0,   0,  9,  9,  12'h508, 8'h02, 1'b1};
    vecs[1] = '{OP_ACK,    3'd3, 3'd0, 64'h0,                0,   0,  1,  1,  12'h50C, 8'h03, 1'b1};
    vecs[2] = '{OP_UNLOCK, 3'd0, 3'd7, 64'h0,                0,   0,  1,  1,  12'h61D, 8'h00, 1'b1};
    vecs[3] = '{OP_LOCK,   3'd0, 3'd5, 64'h0,                2,   0,  3,  11, 12'h614, 8'h00, 1'b0};
    vecs[4] = '{OP_LOCK,   3'd0, 3'd0, 64'h0,                100, 1,  3,  11, 12'h600, 8'h00, 1'b0};
    vecs[5] = '{OP_SEND,   3'd4, 3'd0, 64'hFFFF,             0,   1,  0,  0,  12'h000, 8'h00, 1'b1};
    vecs[6] = '{OP_ACK,    3'd7, 3'd0, 64'h0,                0,   1,  0,  0,  12'h000, 8'h00, 1'b1};
    vecs[7] = '{OP_LOCK,   3'd0, 3'd2, 64'h0,                0,   0,  1,  1,  12'h608, 8'h00, 1'b0};
    vecs[8] = '{OP_SEND,   3'd0, 3'd0, 64'hDEADBEEF0BADF00D, 0,   0,  9,  9,  12'h508, 8'h00, 1'b1};
    vecs[9] = '{OP_UNLOCK, 3'd0, 3'd0, 64'h0,                0,   0,  1,  1,  12'h601, 8'h00, 1'b1};

    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", 64'(bif.cmd_ready), 64'd1);
    chk("rst_done", 64'(bif.done), 64'd0);
    chk("rst_done_err", 64'(bif.done_err), 64'd0);
    chk("rst_bus_req", 64'(bif.bus_req), 64'd0);
    chk("rst_bus_wen", 64'(bif.bus_wen), 64'd0);
    chk("rst_bus_addr", 64'(bif.bus_addr), 64'd0);
    chk("rst_bus_wdata", 64'(bif.bus_wdata), 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_cmd(vecs[i], $sformatf("v%0d", i));
      check_vec(vecs[i], $sformatf("v%0d", i));
    end

    // SEND with a 3-cycle stall on byte 4: same bytes, 3 extra cycles.
    v = vecs[0];
    v.exp_lat = 12;
    stall_idx = 4;
    stall_len = 3;
    run_cmd(v, "stall");
    check_vec(v, "stall");
    chk("stall_cycles_used", 64'(stall_cnt), 64'd3);
    stall_idx = -1;

    // Reset while byte 3 is held pending: engine aborts, SEND never goes out.
    @(negedge clk);
    tx_n = 0;
    stall_cnt = 0;
    stall_idx = 3;
    stall_len = 1000;
    d0 = done_cnt;
    bif.cmd_op = OP_SEND;
    bif.cmd_core = 3'd1;
    bif.cmd_data = 64'h0102030405060708;
    bif.cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    bif.cmd_valid = 1'b0;
    hit = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bif.bus_req && bif.bus_addr == 12'h503) begin
        hit = 1'b1;
        break;
      end
    end
    chk("rst_mid_reached_byte3", 64'(hit), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_bus_req", 64'(bif.bus_req), 64'd0);
    chk("rst_mid_cmd_ready", 64'(bif.cmd_ready), 64'd1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    stall_idx = -1;
    repeat (20) @(negedge clk);
    chk("rst_mid_ntx", 64'(tx_n), 64'd3);
    send_seen = 1'b0;
    for (int i = 0; i < tx_n && i < 64; i++)
      if (tx_addr[i] == 12'h508) send_seen = 1'b1;
    chk("rst_mid_no_send", 64'(send_seen), 64'd0);
    chk("rst_mid_no_done", 64'(done_cnt - d0), 64'd0);
    chk("rst_mid_idle_req", 64'(bif.bus_req), 64'd0);

    run_cmd(vecs[1], "post_rst");
    check_vec(vecs[1], "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
